calc_controller: RTL
====================

Name: calc_controller

Overview:
- Sequencer that streams operand pairs from a single-port SRAM through one adder32 and writes each sum back to a destination region.
- Sits between the top-level calculator control (start/done) and the operand/result memory.
- Software programs the read range and the write base, pulses start, then waits for done.

Parameters:
- DATA_W, 32 (from calculator_pkg): operand/result width.
- ADDR_W, 10 (from calculator_pkg): memory word-address width.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  single-cycle start request; sampled only in IDLE.
- read_start_addr_i  input  ADDR_W  address of the first operand A.
- read_end_addr_i  input  ADDR_W  last address that may be read (inclusive).
- write_start_addr_i  input  ADDR_W  address of the first result.
- mem_rd_en_o  output  1  read strobe.
- mem_rd_addr_o  output  ADDR_W  read address.
- mem_rd_data_i  input  DATA_W  read data, valid exactly 1 cycle after mem_rd_en_o.
- mem_wr_en_o  output  1  write strobe.
- mem_wr_addr_o  output  ADDR_W  write address.
- mem_wr_data_o  output  DATA_W  write data (sum).
- busy_o  output  1  high from the cycle after start is accepted until DONE exits.
- done_o  output  1  one-cycle pulse when the job completes.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - State = IDLE.
  - All outputs = 0.
  - Internal pointers and operand registers = 0.
- Start:
  - In IDLE with start_i=1, latch the three address inputs: rd_ptr <= read_start_addr_i, wr_ptr <= write_start_addr_i, end latched.
  - Go to CHECK.
  - start_i in any other state is ignored.
- CHECK:
  - If rd_ptr+1 <= end (ADDR_W+1-bit compare, no wrap), go to RD_A.
  - Otherwise go to DONE.
- RD_A: mem_rd_en_o=1, mem_rd_addr_o=rd_ptr; go to RD_B.
- RD_B:
  - mem_rd_en_o=1, mem_rd_addr_o=rd_ptr+1.
  - op_a <= mem_rd_data_i.
  - Go to LATCH_B.
- LATCH_B: op_b <= mem_rd_data_i; go to WRITE.
- WRITE:
  - mem_wr_en_o=1, mem_wr_addr_o=wr_ptr, mem_wr_data_o = adder32(op_a, op_b), sum mod 2^DATA_W.
  - rd_ptr += 2 and wr_ptr += 1, both modulo 2^ADDR_W.
  - Go to CHECK.
- DONE: done_o=1 for one cycle, busy_o=1; go to IDLE.
- Throughput and latency:
  - 5 cycles per pair (CHECK, RD_A, RD_B, LATCH_B, WRITE).
  - Job latency from the start cycle = 5*P + 2 cycles, where P = number of pairs.
- Boundaries:
  - Odd word count: the trailing unpaired word is never read.
  - end < start+1: zero reads, zero writes; done_o asserts 2 cycles after start.
  - wr_ptr wraps past 2^ADDR_W-1 to 0.
  - rd_ptr never wraps, because CHECK uses the wide compare.
- Strobes: mem_rd_en_o and mem_wr_en_o are never high in the same cycle. Address and data outputs are 0 whenever their strobe is low.
- Reset mid-job: immediate return to IDLE on the next edge. No further reads or writes; no done_o pulse.
- Combinational paths: none from inputs to outputs; all outputs are decoded from registered state.

Optional Feature:
- Macro: CALC_OVERFLOW_FLAG_EN.
- Defined:
  - Adds output port overflow_o (1 bit).
  - overflow_o is sticky: set in WRITE when the unsigned sum < op_a (carry out lost).
  - Cleared on reset and when a new start is accepted.
  - Reset value 0.
- Undefined: port absent, no extra logic. All other behaviour is identical.

Decomposition:
- calculator_pkg holds DATA_W, ADDR_W and the state enum typedef: IDLE, CHECK, RD_A, RD_B, LATCH_B, WRITE, DONE.
- One sub-module: adder32 is instantiated as the datapath (u_adder), with op_a and op_b as its inputs.
- The controller itself is a single module: state register plus pointer and operand registers.

Test Plan:
- Mem[0..3] = {5, 7, 0xFFFFFFFF, 2}; start=0, end=3, wr=16 -> mem[16]=12, mem[17]=1; exactly 2 writes; done_o at cycle 12 after start; overflow_o=1 if enabled.
- start=4, end=8 (5 words) -> reads only 4..7, writes mem[wr], mem[wr+1]; address 8 never read.
- start=10, end=10 -> no mem_rd_en_o or mem_wr_en_o; done_o 2 cycles after start; busy_o high for exactly that window.
- wr=2^ADDR_W-1 with 2 pairs -> writes land at 1023 then 0.
- Assert rst_i during the RD_B of the second pair -> no write for that pair; no done_o; outputs 0 next cycle; a fresh start then completes normally.
- start_i pulsed while busy -> ignored; the job completes with the originally latched addresses.

Source files
------------

// File: rtl/calculator_pkg.sv
// Shared widths and sequencer state encoding for the calculator datapath.
package calculator_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        RD_A    = 3'd2,
        RD_B    = 3'd3,
        LATCH_B = 3'd4,
        WRITE   = 3'd5,
        DONE    = 3'd6
    } state_e;

endpackage

// File: rtl/adder32.sv
// Unsigned DATA_W-bit adder; the sum wraps modulo 2^DATA_W.
module adder32
    import calculator_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/calc_controller.sv
// Streams operand pairs from SRAM through adder32 and writes sums back.
// Optional sticky carry-out flag: define CALC_OVERFLOW_FLAG_EN.
module calc_controller
    import calculator_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] read_start_addr_i,
    input  logic [ADDR_W-1:0] read_end_addr_i,
    input  logic [ADDR_W-1:0] write_start_addr_i,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_rd_addr_o,
    input  logic [DATA_W-1:0] mem_rd_data_i,
    output logic              mem_wr_en_o,
    output logic [ADDR_W-1:0] mem_wr_addr_o,
    output logic [DATA_W-1:0] mem_wr_data_o,
    output logic              busy_o,
    output logic              done_o
`ifdef CALC_OVERFLOW_FLAG_EN
    ,
    output logic              overflow_o
`endif
);

    localparam int unsigned PTR_W = ADDR_W + 1;

    state_e              state_q, state_d;
    // Read pointer carries one extra bit so the range check never sees a wrap.
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   end_q, end_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   sum;

    adder32 u_adder (
        .a_i   (op_a_q),
        .b_i   (op_b_q),
        .sum_o (sum)
    );

`ifdef CALC_OVERFLOW_FLAG_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        end_d    = end_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
`ifdef CALC_OVERFLOW_FLAG_EN
        ovf_d    = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    rd_ptr_d = {1'b0, read_start_addr_i};
                    wr_ptr_d = write_start_addr_i;
                    end_d    = read_end_addr_i;
`ifdef CALC_OVERFLOW_FLAG_EN
                    ovf_d    = 1'b0;
`endif
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                if ((rd_ptr_q + PTR_W'(1)) <= {1'b0, end_q}) begin
                    state_d = RD_A;
                end else begin
                    state_d = DONE;
                end
            end
            RD_A: state_d = RD_B;
            RD_B: begin
                op_a_d  = mem_rd_data_i;
                state_d = LATCH_B;
            end
            LATCH_B: begin
                op_b_d  = mem_rd_data_i;
                state_d = WRITE;
            end
            WRITE: begin
                rd_ptr_d = rd_ptr_q + PTR_W'(2);
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
`ifdef CALC_OVERFLOW_FLAG_EN
                if (sum < op_a_q) begin
                    ovf_d = 1'b1;
                end
`endif
                state_d  = CHECK;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered copies decoded from the upcoming state.
        rd_en_d   = (state_d == RD_A) || (state_d == RD_B);
        rd_addr_d = '0;
        if (state_d == RD_A) begin
            rd_addr_d = rd_ptr_d[ADDR_W-1:0];
        end else if (state_d == RD_B) begin
            rd_addr_d = rd_ptr_d[ADDR_W-1:0] + ADDR_W'(1);
        end
        wr_en_d   = (state_d == WRITE);
        wr_addr_d = (state_d == WRITE) ? wr_ptr_d : '0;
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            end_q     <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef CALC_OVERFLOW_FLAG_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            end_q     <= end_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef CALC_OVERFLOW_FLAG_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign mem_rd_en_o   = rd_en_q;
    assign mem_rd_addr_o = rd_addr_q;
    assign mem_wr_en_o   = wr_en_q;
    assign mem_wr_addr_o = wr_addr_q;
    // Operands are stable for the whole WRITE cycle, so the sum is gated by the write strobe flop.
    assign mem_wr_data_o = wr_en_q ? sum : '0;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
`ifdef CALC_OVERFLOW_FLAG_EN
    assign overflow_o    = ovf_q;
`endif

endmodule
